// File: rtl/chirp_nco_if.sv
// chirp_nco_if: sweep control, configuration and sample bus for chirp_nco
interface chirp_nco_if #(parameter int PW = 32, OW = 16, CW = 16);
   logic start;
   logic abort;
   logic [1:0] mode;
   logic [PW-1:0] f_start;
   logic [PW-1:0] f_step;
   logic [CW-1:0] n_steps;
   logic [CW-1:0] dwell;
   logic signed [OW-1:0] sin_out;
   logic out_valid;
   logic busy;
   logic done;
   logic [PW-1:0] freq_out;
   modport master(output start, abort, mode, f_start, f_step, n_steps, dwell,
                  input sin_out, out_valid, busy, done, freq_out);
   modport slave(input start, abort, mode, f_start, f_step, n_steps, dwell,
                 output sin_out, out_valid, busy, done, freq_out);
endinterface

// File: rtl/chirp_nco.sv
// chirp_nco: stepped-frequency chirp NCO with quarter-wave sine LUT and 2-stage output pipeline
module chirp_nco #(parameter int PW = 32, AW = 6, OW = 16, CW = 16) (
   input logic clk,
   input logic rst,
   chirp_nco_if.slave bus
);
   typedef enum logic {IDLE, SWEEP} state_t;
   localparam logic signed [OW-1:0] FS = {1'b0, {(OW-1){1'b1}}};
   state_t state, state_nx;
   logic [PW-1:0] phase, freq, fs, fst;
   logic [CW-1:0] step_cnt, dwell_cnt, ns, dw;
   logic [1:0] md;
   logic dir, seg_end, single, last;
   logic [AW-1:0] a;
   logic [1:0] q1;
   logic [AW:0] idx1;
   logic v1, d1, v2, d2;
   logic signed [OW-1:0] mag, sin_r;
   logic signed [OW-1:0] lut [2**AW];

   function automatic logic signed [OW-1:0] lut_val(int k);
      real x;
      x = (2.0 ** (OW - 1) - 1.0) * $sin(3.14159265358979323846 / 2.0 * k / (2.0 ** AW));
      return OW'($rtoi(x + 0.5));
   endfunction

   for (genvar k = 0; k < 2**AW; k++) begin : g_lut
      assign lut[k] = lut_val(k);
   end

   assign single = (md == 2'd0) || (md == 2'd3);
   assign seg_end = (dwell_cnt == dw) && (step_cnt == ns);
   assign a = phase[PW-3 -: AW];
   assign mag = idx1[AW] ? FS : lut[idx1[AW-1:0]];
   assign bus.sin_out = sin_r;
   assign bus.out_valid = v2;
   assign bus.done = d2;
   assign bus.busy = (state == SWEEP);
   assign bus.freq_out = freq;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end

   // next state; abort wins over start, and a completed single sweep flags its last sample
   always_comb begin
      state_nx = state;
      last = 1'b0;
      if (bus.abort) state_nx = IDLE;
      else if (state == IDLE) state_nx = bus.start ? SWEEP : IDLE;
      else if (seg_end && single) begin
         state_nx = IDLE;
         last = 1'b1;
      end
   end

   // sweep datapath: config latch, phase accumulation, dwell/step counting
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
         freq <= '0;
         step_cnt <= '0;
         dwell_cnt <= '0;
         dir <= 1'b0;
         fs <= '0;
         fst <= '0;
         ns <= '0;
         dw <= '0;
         md <= '0;
      end else if (state_nx == IDLE) begin
         phase <= '0;
         freq <= '0;
         step_cnt <= '0;
         dwell_cnt <= '0;
         dir <= 1'b0;
      end else if (state == IDLE) begin
         fs <= bus.f_start;
         fst <= bus.f_step;
         ns <= bus.n_steps;
         dw <= bus.dwell;
         md <= bus.mode;
         freq <= bus.f_start;
         phase <= '0;
         step_cnt <= '0;
         dwell_cnt <= '0;
         dir <= 1'b0;
      end else begin
         phase <= phase + freq;
         if (dwell_cnt != dw) dwell_cnt <= dwell_cnt + CW'(1);
         else begin
            dwell_cnt <= '0;
            if (step_cnt != ns) begin
               step_cnt <= step_cnt + CW'(1);
               freq <= dir ? freq - fst : freq + fst;
            end else begin
               step_cnt <= '0;
               if (md == 2'd1) freq <= fs;
               else dir <= ~dir;
            end
         end
      end
   end

   // output pipeline: stage 1 folds phase into quadrant/index, stage 2 looks up and signs
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         d1 <= 1'b0;
         q1 <= '0;
         idx1 <= '0;
         v2 <= 1'b0;
         d2 <= 1'b0;
         sin_r <= '0;
      end else begin
         v1 <= (state == SWEEP);
         d1 <= last;
         q1 <= phase[PW-1:PW-2];
         idx1 <= phase[PW-2] ? {1'b1, {AW{1'b0}}} - {1'b0, a} : {1'b0, a};
         v2 <= v1;
         d2 <= d1;
         sin_r <= v1 ? (q1[1] ? -mag : mag) : '0;
      end
   end
endmodule
